mem_port_arbiter: RTL

- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM) port.
- Sequences every access over a fixed, parameterised latency.
- Raises a pipeline stall while any request is pending without its acknowledge.
- Sits between the CPU's IF/MEM stages and the memory array; its stall output joins the CPU's existing stall/flush logic.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM pipeline ports.
// Each access runs IDLE -> BUSY (LAT cycles) -> ACK; MEM has priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              stall_o
);
  localparam int CW = 3;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              gnt_mem_q, gnt_mem_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              starved;

  assign starved = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    gnt_mem_d   = gnt_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (start_i && (if_req_i || mem_req_i)) begin
          // IF only beats a competing MEM request once it has been starved out
          gnt_mem_d = mem_req_i && !(if_req_i && starved);
          if (gnt_mem_d) begin
            starve_d = if_req_i ? (starved ? starve_q : starve_q + SW'(1)) : '0;
            we_d     = mem_we_i;
            addr_d   = mem_addr_i;
            wdata_d  = mem_wdata_i;
          end else begin
            starve_d = '0;
            we_d     = 1'b0;
            addr_d   = if_addr_i;
          end
          lat_d   = CW'(LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (lat_q != '0) begin
          lat_d = lat_q - CW'(1);
        end else begin
          if (!we_q) begin
            if (gnt_mem_q) mem_rdata_d = ram_rdata_i;
            else           if_rdata_d  = ram_rdata_i;
          end
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      gnt_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      gnt_mem_q   <= gnt_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_en_o    = (state_q == BUSY);
  assign ram_we_o    = (state_q == BUSY) && we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_ack_o    = (state_q == ACK) && !gnt_mem_q;
  assign mem_ack_o   = (state_q == ACK) && gnt_mem_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  // Held low in reset so every output reads 0 while rst_i is asserted
  assign stall_o = rst_i & ((if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o));
endmodule
